// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS tap sequencer: FSM state, precision
// encodings, lane count and adder lane-split mapping.
package lms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILT,
    FLUSH,
    ERR,
    UPD,
    DRAIN
  } state_t;

  localparam logic [1:0] PREC_8 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_2 = 2'b10;

  typedef struct packed {
    logic s0;
    logic s1;
    logic s2;
  } lane_ctl_t;

  // Encoding 11 is treated as one 8-bit lane.
  function automatic logic [2:0] lane_count(input logic [1:0] prc);
    case (prc)
      PREC_4:  return 3'd2;
      PREC_2:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic lane_ctl_t lane_map(input logic [1:0] prc);
    case (prc)
      PREC_4:  return '{s0: 1'b1, s1: 1'b1, s2: 1'b0};
      PREC_2:  return '{s0: 1'b0, s1: 1'b0, s2: 1'b0};
      default: return '{s0: 1'b1, s1: 1'b1, s2: 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/lms_tap_sequencer_if.sv
// Sample handshake, datapath control and memory address bundle of the LMS tap
// sequencer. Carries freeze only when LMS_SEQ_FREEZE_EN is defined.
interface lms_tap_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    prec;
  logic          err_neg;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          acc_clr;
  logic          acc_en;
  logic          s0;
  logic          s1;
  logic          s2;
  logic          a;
  logic          b;
`ifdef LMS_SEQ_FREEZE_EN
  logic          freeze;

  modport master (
    input  in_valid, prec, err_neg, out_ready, freeze,
    output in_ready, out_valid, rd_addr, wr_addr, wr_en, acc_clr, acc_en,
           s0, s1, s2, a, b
  );
  modport slave (
    output in_valid, prec, err_neg, out_ready, freeze,
    input  in_ready, out_valid, rd_addr, wr_addr, wr_en, acc_clr, acc_en,
           s0, s1, s2, a, b
  );
`else
  modport master (
    input  in_valid, prec, err_neg, out_ready,
    output in_ready, out_valid, rd_addr, wr_addr, wr_en, acc_clr, acc_en,
           s0, s1, s2, a, b
  );
  modport slave (
    output in_valid, prec, err_neg, out_ready,
    input  in_ready, out_valid, rd_addr, wr_addr, wr_en, acc_clr, acc_en,
           s0, s1, s2, a, b
  );
`endif
endinterface

// File: rtl/lms_lane_decode.sv
// Decodes a latched precision code into lane count and adder lane-split
// controls; shared with the datapath wrapper.
module lms_lane_decode
  import lms_pkg::*;
(
  input  logic [1:0] prc,
  output logic [2:0] lanes,
  output logic       s0,
  output logic       s1,
  output logic       s2
);
  lane_ctl_t ctl;

  always_comb begin
    lanes = lane_count(prc);
    ctl   = lane_map(prc);
    s0    = ctl.s0;
    s1    = ctl.s1;
    s2    = ctl.s2;
  end
endmodule

// File: rtl/lms_tap_sequencer.sv
// Per-sample sequencer for the shared LMS adder datapath: filter pass, error
// step, weight-update pass. Optional freeze input under LMS_SEQ_FREEZE_EN.
module lms_tap_sequencer
  import lms_pkg::*;
#(
  parameter int unsigned TAPS = 16,
  parameter int unsigned AW   = $clog2(TAPS)
) (
  input logic                 clk,
  input logic                 rst_n,
  lms_tap_sequencer_if.master bus
);
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    prc_q;
  logic          sgn_q;
  logic          ov_q, ov_d;
  logic          acc_en_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
`ifdef LMS_SEQ_FREEZE_EN
  logic          frz_q;
`endif

  logic [2:0]    lanes;
  logic          ls0, ls1, ls2;
  logic          accept, err_go, last, busy, out_valid;

  lms_lane_decode u_dec (
    .prc  (prc_q),
    .lanes(lanes),
    .s0   (ls0),
    .s1   (ls1),
    .s2   (ls2)
  );

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign err_go    = (state_q == ERR) && (!ov_q || bus.out_ready);
  assign last      = ({1'b0, addr_q} + (AW+1)'(lanes)) == (AW+1)'(TAPS);
  assign busy      = (state_q != IDLE);
  // y becomes visible in ERR itself; ov_q holds it until consumed afterwards.
  assign out_valid = ov_q || (state_q == ERR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ov_d    = (out_valid && bus.out_ready) ? 1'b0 : ov_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = FILT;
          addr_d  = '0;
        end
      end
      FILT: begin
        if (last) begin
          addr_d  = '0;
          state_d = FLUSH;
        end else begin
          addr_d = addr_q + AW'(lanes);
        end
      end
      FLUSH: state_d = ERR;
      ERR: begin
        if (err_go) begin
          ov_d = 1'b1;
`ifdef LMS_SEQ_FREEZE_EN
          state_d = frz_q ? IDLE : UPD;
`else
          state_d = UPD;
`endif
        end
      end
      UPD: begin
        if (last) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + AW'(lanes);
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      prc_q     <= PREC_8;
      sgn_q     <= 1'b0;
      ov_q      <= 1'b0;
      acc_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
`ifdef LMS_SEQ_FREEZE_EN
      frz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ov_q      <= ov_d;
      acc_en_q  <= (state_q == FILT);
      wr_en_q   <= (state_q == UPD);
      wr_addr_q <= addr_q;
      if (accept) begin
        prc_q <= bus.prec;
`ifdef LMS_SEQ_FREEZE_EN
        frz_q <= bus.freeze;
`endif
      end
      if (err_go) sgn_q <= bus.err_neg;
    end
  end

  assign bus.in_ready  = !busy;
  assign bus.out_valid = out_valid;
  assign bus.acc_clr   = accept;
  assign bus.acc_en    = acc_en_q;
  assign bus.rd_addr   = addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  // Lane controls are held low while idle so reset leaves every output at 0.
  assign bus.s0        = busy && ls0;
  assign bus.s1        = busy && ls1;
  assign bus.s2        = busy && ls2;
  assign bus.a         = (state_q == ERR) || ((state_q == UPD) && sgn_q);
  assign bus.b         = 1'b0;
endmodule

// File: tb/tb_lms_tap_sequencer.sv
// Self-checking bench for lms_tap_sequencer (TAPS=16): per-precision table,
// randomized passes against a cycle-schedule model, and corner sequences.
module tb_lms_tap_sequencer;
  localparam int unsigned TAPS = 16;
  localparam int unsigned AW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lms_tap_sequencer_if #(.AW(AW)) bus ();

  lms_tap_sequencer #(.TAPS(TAPS), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] prec;
    logic [2:0] s_exp;
    int         ret_exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({name, ".others"},
        32'({bus.out_valid, bus.rd_addr, bus.wr_addr, bus.wr_en, bus.acc_clr,
             bus.acc_en, bus.s0, bus.s1, bus.s2, bus.a, bus.b}), 32'd0);
  endtask

  task automatic set_freeze(input logic f);
`ifdef LMS_SEQ_FREEZE_EN
    bus.freeze = f;
`else
    if (f) $display("freeze request ignored in this build");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single sample from IDLE with out_valid clear and out_ready held low.
  // Expectations follow the per-sample schedule: reads at 1..N, acc_en 2..N+1,
  // ERR at N+2, update reads N+3..2N+2, writes N+4..2N+3, idle at 2N+4.
  task automatic run_pass(input logic [1:0] p, input logic en, input logic fz_in,
                          output logic [2:0] s_obs, output int ret);
    int L, N, done, c;
    logic fz;
    logic [2:0] s_exp;
    logic iss1, iss2, exp_wr;
    int exp_rd, exp_wa;
`ifdef LMS_SEQ_FREEZE_EN
    fz = fz_in;
`else
    fz = 1'b0;
`endif
    case (p)
      2'd1: L = 2;
      2'd2: L = 4;
      default: L = 1;
    endcase
    N = TAPS / L;
    s_exp = (L == 1) ? 3'b111 : (L == 2) ? 3'b110 : 3'b000;
    done = fz ? N + 3 : 2 * N + 4;
    s_obs = 3'bxxx;
    ret = -1;

    @(negedge clk);
    bus.prec = p;
    bus.err_neg = en;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    set_freeze(fz_in);
    #1;
    chk("accept.in_ready", 32'(bus.in_ready), 32'd1);
    chk("accept.acc_clr", 32'(bus.acc_clr), 32'd1);

    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.in_valid = (c < done) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.prec = 2'($urandom_range(0, 3));
      set_freeze(1'($urandom_range(0, 1)));
      #1;
      iss1 = (c >= 1) && (c <= N);
      iss2 = !fz && (c >= N + 3) && (c <= 2 * N + 2);
      exp_wr = !fz && (c >= N + 4) && (c <= 2 * N + 3);
      exp_rd = iss1 ? (c - 1) * L : (c - N - 3) * L;
      exp_wa = (c - N - 4) * L;
      if (c == 1) s_obs = {bus.s0, bus.s1, bus.s2};
      chk("in_ready", 32'(bus.in_ready), 32'(c >= done));
      chk("acc_clr", 32'(bus.acc_clr), 32'd0);
      chk("acc_en", 32'(bus.acc_en), 32'((c >= 2) && (c <= N + 1)));
      chk("wr_en", 32'(bus.wr_en), 32'(exp_wr));
      chk("out_valid", 32'(bus.out_valid), 32'(c >= N + 2));
      chk("a", 32'(bus.a), 32'((c == N + 2) || (iss2 && en)));
      chk("b", 32'(bus.b), 32'd0);
      chk("lanes", 32'({bus.s0, bus.s1, bus.s2}), 32'((c < done) ? s_exp : 3'b000));
      if (iss1 || iss2) chk("rd_addr", 32'(bus.rd_addr), 32'(exp_rd));
      if (exp_wr) chk("wr_addr", 32'(bus.wr_addr), 32'(exp_wa));
      if (bus.in_ready) begin
        ret = c;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  vec_t tbl[4];
  logic [2:0] s_obs;
  int ret;
  int wr_seen;

  initial begin
    bus.in_valid = 1'b0;
    bus.prec = 2'b00;
    bus.err_neg = 1'b0;
    bus.out_ready = 1'b0;
    set_freeze(1'b0);

    tbl[0] = '{prec: 2'b00, s_exp: 3'b111, ret_exp: 36};
    tbl[1] = '{prec: 2'b01, s_exp: 3'b110, ret_exp: 20};
    tbl[2] = '{prec: 2'b10, s_exp: 3'b000, ret_exp: 12};
    tbl[3] = '{prec: 2'b11, s_exp: 3'b111, ret_exp: 36};

    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_pass(tbl[i].prec, 1'(i % 2), 1'b0, s_obs, ret);
      chk("tbl.lanes", 32'(s_obs), 32'(tbl[i].s_exp));
      chk("tbl.ret", 32'(ret), 32'(tbl[i].ret_exp));
      drain_out();
    end

    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_pass(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, s_obs, ret);
      drain_out();
    end

    // ERR stall: previous y left unconsumed, second pass waits in ERR.
    run_pass(2'b10, 1'b1, 1'b0, s_obs, ret);
    @(negedge clk);
    bus.prec = 2'b10;
    bus.err_neg = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (c == 10) bus.out_ready = 1'b1;
      #1;
      if (c >= 6) begin
        chk("stall.a", 32'(bus.a), 32'd1);
        chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall.wr_en", 32'(bus.wr_en), 32'd0);
        chk("stall.out_valid", 32'(bus.out_valid), 32'd1);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("resume.out_valid", 32'(bus.out_valid), 32'd1);
    chk("resume.a", 32'(bus.a), 32'd0);
    chk("resume.rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("resume.wr_en", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    #1;
    chk("resume.wr_en1", 32'(bus.wr_en), 32'd1);
    chk("resume.wr_addr", 32'(bus.wr_addr), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("resume.drain_busy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("resume.idle", 32'(bus.in_ready), 32'd1);
    drain_out();

    // Reset mid-UPD, prec 00, cycle 25.
    @(negedge clk);
    bus.prec = 2'b00;
    bus.err_neg = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    #1;
    chk("pre_rst.wr_en", 32'(bus.wr_en), 32'd1);
    chk("pre_rst.wr_addr", 32'(bus.wr_addr), 32'd5);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    @(negedge clk);
    #1;
    chk("mid_rst.in_ready_next", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (bus.wr_en) wr_seen++;
    end
    chk("post_rst.no_wr", 32'(wr_seen), 32'd0);
    chk_idle_outputs("post_rst");

    // in_valid held high: next sample accepted on the first IDLE cycle.
    @(negedge clk);
    bus.prec = 2'b10;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      #1;
      if (c == 11) chk("b2b.busy", 32'(bus.in_ready), 32'd0);
      if (c == 12) begin
        chk("b2b.ready", 32'(bus.in_ready), 32'd1);
        chk("b2b.acc_clr", 32'(bus.acc_clr), 32'd1);
      end
      if (c == 13) chk("b2b.accepted", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

`ifdef LMS_SEQ_FREEZE_EN
    run_pass(2'b01, 1'b1, 1'b1, s_obs, ret);
    chk("freeze.ret", 32'(ret), 32'd11);
    drain_out();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lms_tap_sequencer.md
# lms_tap_sequencer

Controller for the adaptive filter's shared precision-configurable adder/accumulator datapath. Per accepted input sample it sequences the filter pass, the error step and the weight-update pass over all taps. It drives the weight/sample memory addresses, the adder's lane-split controls (s0, s1, s2) and the operand-negate controls (a, b). It does no arithmetic itself; the datapath reports the error sign back.

## Interface
- TAPS, 16: number of filter taps (≥4, multiple of 4).
- AW, $clog2(TAPS): tap address width.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  new sample (x, d) available.
- in_ready  out  1  sequencer idle and can accept a sample.
- prec  in  2  lane precision, sampled on the input handshake only: 00 = one 8-bit lane, 01 = two 4-bit lanes, 10 = four 2-bit lanes, 11 treated as 00.
- err_neg  in  1  datapath error sign, valid in ERR.
- out_valid  out  1  filter output y available in datapath output register.
- out_ready  in  1  downstream consumes y.
- rd_addr  out  AW  tap read address (weights and samples, 1-cycle read latency).
- wr_addr  out  AW  weight write address.
- wr_en  out  1  weight write strobe.
- acc_clr  out  1  clear accumulator.
- acc_en  out  1  accumulate current read data.
- s0, s1, s2  out  1 each  adder lane-split controls.
- a, b  out  1 each  negate x-operand / w-operand.

## Operation
- Lane count L: 1/2/4 for prec 00/01/10. Issue count N = TAPS/L. rd_addr steps by L.
- Lane controls come from the precision latched at acceptance (prc_q):
  - 00 → s0=1, s1=1, s2=1.
  - 01 → s0=1, s1=1, s2=0.
  - 10 → s0=0, s1=0, s2=0.
- FSM states: IDLE, FILT, FLUSH, ERR, UPD, DRAIN.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch prec, pulse acc_clr, rd_addr=0, go to FILT.
- FILT:
  - Issue N reads, addresses 0, L, 2L, …
  - acc_en asserts one cycle after each issue.
  - a=0, b=0.
  - After the last issue, go to FLUSH.
- FLUSH: last acc_en; go to ERR.
- ERR:
  - a=1 (d − y).
  - out_valid sets if clear. If out_valid is still set from the previous sample, stay in ERR until out_ready.
  - Capture err_neg into sgn_q; go to UPD.
- UPD:
  - Reissue N reads from address 0.
  - a=sgn_q, b=0.
  - wr_en and wr_addr follow each read by one cycle.
- DRAIN: final write; go to IDLE.
- out_valid clears on out_valid&out_ready. Clearing and setting in the same cycle leaves it set.
- in_valid while busy is ignored. prec changes while busy are ignored.
- Reset, at any time including mid-pass:
  - FSM to IDLE, in_ready=1.
  - All other outputs 0, prc_q=00.
  - Any pending write is dropped.

## Timing
- Busy period is 2N+3 cycles after the accepting edge. in_ready is high again on cycle 2N+4, absent an ERR stall.
- TAPS=16:
  - prec 00: N=16, in_ready returns at cycle 36.
  - prec 01: N=8, cycle 20.
  - prec 10: N=4, cycle 12.
- out_valid rises in the ERR cycle, N+2 cycles after acceptance.
- Read-to-accumulate latency and read-to-write latency are both 1 cycle.
- Back-to-back operation: in_valid held high is accepted on the first IDLE cycle.

## Configuration
- LMS_SEQ_FREEZE_EN:
  - Defined: adds input freeze (1 bit), sampled on the input handshake. A frozen sample skips UPD/DRAIN: ERR goes directly to IDLE, no wr_en, busy period N+2.
  - Undefined: no port; every sample updates the weights.

## Structure
- Shared package lms_pkg:
  - State enum.
  - Precision encoding constants (PREC_8, PREC_4, PREC_2).
  - Lane-count function and s0/s1/s2 mapping function.
- One sub-module: lms_lane_decode (prc_q → L, s0, s1, s2), reused by the datapath wrapper.
- Address counter and FSM live in the top module.

## Test plan
- Reset mid-UPD (TAPS=16, prec 00, cycle 25): all outputs 0, in_ready=1 next cycle, no wr_en afterwards.
- prec 00, one sample: 16 reads at 0..15, acc_en cycles 2..17, out_valid at cycle 18, writes 0..15 on cycles 20..35, in_ready at 36.
- prec 10: s0=s1=s2=0, reads at 0,4,8,12, in_ready at cycle 12.
- err_neg=1 in ERR: a=1 throughout UPD. With err_neg=0: a=0 throughout UPD.
- out_ready held 0 across two samples: second pass stalls in ERR. Releasing out_ready resumes UPD the next cycle, and out_valid stays 1.
- LMS_SEQ_FREEZE_EN with freeze=1, prec 01: no wr_en, in_ready back at cycle 11.
